// File: rtl/updown_counter_pkg.sv
// Shared constants for the up/down counter: encoding of the incrementer's
// prefix-structure selector.
package updown_counter_pkg;

  localparam int SPEED_SERIAL = 0;
  localparam int SPEED_BK     = 1;
  localparam int SPEED_SKL    = 2;

endpackage

// File: rtl/IncDec.sv
// Combinational incrementer/decrementer: y_o = a_i + 1 (dec_i=0) or a_i - 1 (dec_i=1), modulo 2^width.
// Bit i toggles when all lower bits are 1 (inc) or 0 (dec); speed picks the prefix-AND network.
module IncDec
  import updown_counter_pkg::*;
#(
  parameter int width = 8,
  parameter int speed = SPEED_SERIAL
) (
  input  logic [width-1:0] a_i,
  input  logic             dec_i,
  output logic [width-1:0] y_o
);

  localparam int N  = width - 1;
  localparam int LG = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] p;
  logic [N-1:0] pre;

  assign p   = dec_i ? ~a_i[N-1:0] : a_i[N-1:0];
  assign y_o = a_i ^ {pre, 1'b1};

  if (speed == SPEED_SKL) begin : g_sklansky
    for (genvar l = 0; l < LG; l++) begin : g_lvl
      logic [N-1:0] prv;
      logic [N-1:0] nxt;
      if (l == 0) begin : g_in
        assign prv = p;
      end else begin : g_chain
        assign prv = g_lvl[l-1].nxt;
      end
      for (genvar i = 0; i < N; i++) begin : g_bit
        if (((i >> l) & 1) == 1) begin : g_op
          assign nxt[i] = prv[i] & prv[((i >> l) << l) - 1];
        end else begin : g_pass
          assign nxt[i] = prv[i];
        end
      end
    end
    assign pre = g_lvl[LG-1].nxt;

  end else if (speed == SPEED_BK) begin : g_brent_kung
    // Stages 0..LG-1 are the up-sweep, the rest fill in the odd positions on the way down.
    for (genvar s = 0; s < 2*LG-1; s++) begin : g_stg
      localparam int  L  = (s < LG) ? s : 2*LG-2-s;
      localparam bit  UP = (s < LG);
      logic [N-1:0] prv;
      logic [N-1:0] nxt;
      if (s == 0) begin : g_in
        assign prv = p;
      end else begin : g_chain
        assign prv = g_stg[s-1].nxt;
      end
      for (genvar i = 0; i < N; i++) begin : g_bit
        if (UP ? (((i + 1) % (2**(L+1))) == 0)
               : ((i >= 2**(L+1)) && (((i + 1) % (2**(L+1))) == 2**L))) begin : g_op
          assign nxt[i] = prv[i] & prv[i - 2**L];
        end else begin : g_pass
          assign nxt[i] = prv[i];
        end
      end
    end
    assign pre = g_stg[2*LG-2].nxt;

  end else begin : g_serial
    always_comb begin
      logic acc;
      // NOTE: blocking assignments in combinational logic; acc is a running temporary.
      acc = 1'b1;
      for (int i = 0; i < N; i++) begin
        acc    = acc & p[i];
        pre[i] = acc;
      end
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Registered up/down counter with wrap or saturate boundary handling.
// Optional sticky overflow flag with clear input when UPDOWN_COUNTER_STICKY_EN is defined.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int               width   = 8,
  parameter int               speed   = SPEED_SERIAL,
  parameter logic [width-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             LD,
  input  logic [width-1:0] D,
  input  logic             EN,
  input  logic             DEC,
  input  logic             SAT,
  output logic [width-1:0] Q,
  output logic             TC,
  output logic             OVF
`ifdef UPDOWN_COUNTER_STICKY_EN
  ,
  input  logic             OVF_CLR,
  output logic             OVF_STICKY
`endif
);

  logic [width-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic [width-1:0] cand;

  IncDec #(.width(width), .speed(speed)) u_incdec (
    .a_i  (q_q),
    .dec_i(DEC),
    .y_o  (cand)
  );

  assign TC = DEC ? ~|q_q : &q_q;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    q_d   = q_q;
    ovf_d = 1'b0;
    if (LD) begin
      q_d = D;
    end else if (EN) begin
      ovf_d = TC;
      if (!(TC && SAT)) q_d = cand;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q   <= RST_VAL;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign OVF = ovf_q;

`ifdef UPDOWN_COUNTER_STICKY_EN
  logic sticky_q, sticky_d;

  // A boundary event landing on the same edge as a clear keeps the flag set.
  assign sticky_d = ovf_d | (sticky_q & ~OVF_CLR);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sticky_q <= 1'b0;
    else         sticky_q <= sticky_d;
  end

  assign OVF_STICKY = sticky_q;
`endif

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
- Registered up/down counter built on the combinational `IncDec` block.
- Holds a `width`-bit state `Q`, which can be loaded, stepped up by 1, or stepped down by 1 on each clock.
- Supports wrap-around or saturating boundary handling.
- Used for address walkers, credit counters and FIFO occupancy tracking; `speed` selects the prefix structure inside the incrementer.

Parameters:
- width, 8, counter word width; legal values ≥ 2.
- speed, 0, prefix structure of the internal `IncDec`: 0 = serial, 1 = Brent-Kung, 2 = Sklansky.
- RST_VAL, 0, value of `Q` after reset; width bits.

Ports:
- clk_i  in  1  clock; rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- LD  in  1  load enable.
- D  in  width  load value.
- EN  in  1  count enable.
- DEC  in  1  direction: 0 = increment, 1 = decrement.
- SAT  in  1  boundary mode: 0 = wrap, 1 = saturate.
- Q  out  width  counter state, registered.
- TC  out  1  terminal count, combinational from `Q` and `DEC`: 1 when `DEC`=0 and `Q`=all-ones, or when `DEC`=1 and `Q`=0.
- OVF  out  1  boundary-event pulse, registered.

Behaviour:
- Reset
  - Synchronous, active-low.
  - `rst_ni`=0 at a rising edge sets `Q`=`RST_VAL` and `OVF`=0.
  - Reset overrides `LD` and `EN` in the same cycle.
- Priority per edge: reset > `LD` > `EN` > hold.
- Load: `LD`=1 sets `Q`←`D` and `OVF`←0, regardless of `EN`, `DEC` and `SAT`.
- Step (`EN`=1, `LD`=0)
  - The candidate next value is `IncDec(Q, DEC)`, i.e. Q±1 mod 2^width.
  - If `TC`=0: `Q`←candidate, `OVF`←0.
  - If `TC`=1 and `SAT`=0: `Q`←candidate (wraps all-ones→0 or 0→all-ones), `OVF`←1.
  - If `TC`=1 and `SAT`=1: `Q` holds, `OVF`←1.
- Hold (`EN`=0, `LD`=0): `Q` holds, `OVF`←0.
- Timing
  - `OVF` is high for exactly one cycle per boundary event.
  - Consecutive saturated steps at the boundary raise `OVF` on every such cycle.
  - Latency is one cycle: `Q` reflects a step or load on the edge where `EN` or `LD` is sampled.
- `TC` depends on the current `DEC`, so a direction change alters `TC` in the same cycle.
- `DEC` and `SAT` are don't-care when `EN`=0 and `LD`=0.
- Arithmetic is modulo 2^width; no carry-out beyond `OVF`.

Optional Feature:
- Macro: `UPDOWN_COUNTER_STICKY_EN`.
- Defined
  - Adds input `OVF_CLR` (1 bit) and output `OVF_STICKY` (1 bit), registered, reset 0.
  - `OVF_STICKY` sets on any cycle whose registered `OVF` becomes 1.
  - It clears when `OVF_CLR`=1; set wins over clear in the same cycle.
  - `LD` does not clear it.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package `updown_counter_pkg` holds the speed encoding constants: `SPEED_SERIAL`=0, `SPEED_BK`=1, `SPEED_SKL`=2.
- One sub-module: the existing `IncDec`, instantiated with (`width`, `speed`) to form the candidate.
- `TC` uses reduction AND/NOR on `Q`, not a second adder.

Test Plan:
1. Reset and up-count: width=8; hold `rst_ni`=0 for 2 cycles, release; `EN`=1, `DEC`=0 for 5 cycles → `Q` goes 0,1,2,3,4,5 and `OVF` stays 0.
2. Wrap up: `LD` with `D`=0xFE, then `EN`=1, `DEC`=0, `SAT`=0 for 3 cycles → `Q` goes 0xFF, 0x00, 0x01; `TC`=1 only while `Q`=0xFF; `OVF`=1 only in the cycle `Q`=0x00.
3. Saturate down: `LD` with `D`=0x01, then `EN`=1, `DEC`=1, `SAT`=1 for 3 cycles → `Q` goes 0x00, 0x00, 0x00; `OVF` goes 0, 1, 1.
4. Priority: `LD`=1 with `D`=0x5A and `EN`=1, `DEC`=1 in the same cycle → `Q`=0x5A; then assert `rst_ni`=0 together with `LD`=1 → `Q`=`RST_VAL`.
5. Speed sweep: repeat tests 1–3 for speed 0, 1, 2 and width 8 and 13, with a random `EN`/`DEC`/`LD` stream for 10k cycles → `Q` matches a reference model every cycle.
6. Sticky (`UPDOWN_COUNTER_STICKY_EN` defined): trigger a wrap, then issue `OVF_CLR` 3 cycles later → `OVF_STICKY` is 1 from the `OVF` cycle until the clear, then 0; `OVF` together with `OVF_CLR` in the same cycle → `OVF_STICKY` stays 1.
